// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state, payload types and constants for elastic pipeline registers
package pipe_pkg;

   // Occupancy of an elastic register: nothing, main slot only, main plus skid slot.
   typedef enum logic [1:0] {
      PIPE_EMPTY = 2'd0,
      PIPE_ONE   = 2'd1,
      PIPE_FULL  = 2'd2
   } pipe_state_e;

   // addi x0, x0, 0
   localparam logic [31:0] RV_NOP = 32'h0000_0013;

   // IF/ID stage payload; field order sets the packed bit layout {instr, pc, pc_plus4}.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
   } if_id_payload_t;

   localparam int IF_ID_WIDTH = $bits(if_id_payload_t);

   localparam if_id_payload_t IF_ID_NOP = '{instr: RV_NOP, pc: 32'h0, pc_plus4: 32'h0};

endpackage

// File: rtl/elastic_pipe_perf.sv
// rtl/elastic_pipe_perf.sv - saturating stall and flush event counters for elastic_pipe_reg
module elastic_pipe_perf (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_event_i,
   input  logic        flush_event_i,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
);

   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   // Increment on each event, sticking at all-ones instead of wrapping.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_event_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (flush_event_i && (flush_cnt_q != 32'hFFFF_FFFF)) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end
   end

   // Counters are cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule

// File: rtl/elastic_pipe_reg.sv
// rtl/elastic_pipe_reg.sv - valid/ready pipeline register with 2-entry skid and flush; ELASTIC_PIPE_REG_PERF_EN adds stall/flush counters
module elastic_pipe_reg
   import pipe_pkg::*;
#(
   parameter int                       PAYLOAD_WIDTH = IF_ID_WIDTH,
   parameter bit                       FLUSH_NOP     = 1'b1,
   parameter logic [PAYLOAD_WIDTH-1:0] NOP_PAYLOAD   = PAYLOAD_WIDTH'(IF_ID_NOP)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [PAYLOAD_WIDTH-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PAYLOAD_WIDTH-1:0] out_data
`ifdef ELASTIC_PIPE_REG_PERF_EN
   ,
   output logic [31:0]              stall_cnt,
   output logic [31:0]              flush_cnt
`endif
);

   pipe_state_e              state_q, state_d;
   logic [PAYLOAD_WIDTH-1:0] main_q, main_d;
   logic [PAYLOAD_WIDTH-1:0] skid_q, skid_d;
   logic                     in_fire;
   logic                     out_fire;

   // in_ready is a function of registered state only, so backpressure never
   // forms a combinational path from out_ready to upstream.
   assign in_ready  = (state_q != PIPE_FULL) & ~rst;
   assign out_valid = (state_q != PIPE_EMPTY);
   assign out_data  = main_q;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   // Next-state and slot updates; flush overrides the normal handshake moves.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         // Held beats and any beat accepted this cycle are discarded.
         if (FLUSH_NOP) begin
            state_d = PIPE_ONE;
            main_d  = NOP_PAYLOAD;
         end else begin
            state_d = PIPE_EMPTY;
         end
      end else begin
         unique case (state_q)
            PIPE_EMPTY: begin
               if (in_fire) begin
                  state_d = PIPE_ONE;
                  main_d  = in_data;
               end
            end
            PIPE_ONE: begin
               if (in_fire && out_fire) begin
                  main_d = in_data;
               end else if (in_fire) begin
                  state_d = PIPE_FULL;
                  skid_d  = in_data;
               end else if (out_fire) begin
                  state_d = PIPE_EMPTY;
               end
            end
            PIPE_FULL: begin
               // in_ready is low here, so only the drain side can move.
               if (out_fire) begin
                  state_d = PIPE_ONE;
                  main_d  = skid_q;
               end
            end
            default: begin
               state_d = PIPE_EMPTY;
            end
         endcase
      end
   end

   // Register the state and both slots; reset beats flush and drops everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PIPE_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

`ifdef ELASTIC_PIPE_REG_PERF_EN
   logic stall_event;
   logic flush_event;

   assign stall_event = out_valid & ~out_ready;
   assign flush_event = flush & (state_q != PIPE_EMPTY);

   elastic_pipe_perf u_perf (
      .clk           (clk),
      .rst           (rst),
      .stall_event_i (stall_event),
      .flush_event_i (flush_event),
      .stall_cnt_o   (stall_cnt),
      .flush_cnt_o   (flush_cnt)
   );
`endif

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// tb/tb_elastic_pipe_reg.sv - scoreboard bench for elastic_pipe_reg, FLUSH_NOP=0 and FLUSH_NOP=1 side by side
module tb_elastic_pipe_reg;
   import pipe_pkg::*;

   localparam int W = IF_ID_WIDTH;
   localparam logic [W-1:0] NOP = W'(IF_ID_NOP);
   typedef logic [W-1:0] beat_t;

   logic  clk;
   logic  rst;
   logic  flush;
   logic  out_ready;
   logic  in_valid  [2];
   logic  in_ready  [2];
   beat_t in_data   [2];
   logic  out_valid [2];
   beat_t out_data  [2];
`ifdef ELASTIC_PIPE_REG_PERF_EN
   logic [31:0] stall_cnt [2];
   logic [31:0] flush_cnt [2];
   int unsigned stall_m   [2];
   int unsigned flush_m   [2];
`endif

   // Expected contents of each register, oldest first.
   beat_t exp_q [2][$];
   bit    zero_flag [2];
   bit    fired     [2];
   beat_t next_val  [2];
   bit    rand_data;
   bit    mon_en;
   int    n_checks;
   int    n_errors;

   // Instance 0 empties on flush, instance 1 injects a NOP.
   for (genvar g = 0; g < 2; g++) begin : g_dut
      elastic_pipe_reg #(
         .PAYLOAD_WIDTH (W),
         .FLUSH_NOP     (g == 1),
         .NOP_PAYLOAD   (NOP)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .flush     (flush),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_data   (in_data[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready),
         .out_data  (out_data[g])
`ifdef ELASTIC_PIPE_REG_PERF_EN
         ,
         .stall_cnt (stall_cnt[g]),
         .flush_cnt (flush_cnt[g])
`endif
      );
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int k, input beat_t act, input beat_t exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s dut%0d: got %h expected %h", name, k, act, exp);
      end
   endtask

   // Monitor: compares DUT outputs with the scoreboard 2 time units before each posedge.
   always begin
      @(negedge clk);
      #3;
      if (mon_en) begin
         for (int k = 0; k < 2; k++) begin
            automatic int sz = exp_q[k].size();
            chk("in_ready", k, beat_t'(in_ready[k]), beat_t'(!rst && sz < 2));
            chk("out_valid", k, beat_t'(out_valid[k]), beat_t'(sz > 0));
            if (out_valid[k] === 1'b1 && sz > 0) begin
               chk("out_data", k, out_data[k], exp_q[k][0]);
               if (out_ready) void'(exp_q[k].pop_front());
            end else if (sz == 0 && zero_flag[k]) begin
               chk("out_data_reset", k, out_data[k], '0);
            end
`ifdef ELASTIC_PIPE_REG_PERF_EN
            chk("stall_cnt", k, beat_t'(stall_cnt[k]), beat_t'(stall_m[k]));
            chk("flush_cnt", k, beat_t'(flush_cnt[k]), beat_t'(flush_m[k]));
            if (rst) begin
               stall_m[k] = 0;
               flush_m[k] = 0;
            end else begin
               if (sz > 0 && !out_ready) stall_m[k]++;
               if (flush && sz > 0) flush_m[k]++;
            end
`endif
         end
      end
   end

   // One clock of stimulus; afterwards records what each register should now hold.
   task automatic step(input bit r, input bit f, input bit ordy, input bit offer);
      @(negedge clk);
      rst       = r;
      flush     = f;
      out_ready = ordy;
      for (int k = 0; k < 2; k++) begin
         if (fired[k]) in_valid[k] = 1'b0;
         fired[k] = 1'b0;
         if (!in_valid[k] && offer) begin
            in_valid[k] = 1'b1;
            in_data[k]  = rand_data ? {$urandom, $urandom, $urandom} : next_val[k];
            next_val[k] = next_val[k] + 1'b1;
         end
      end
      #4;
      for (int k = 0; k < 2; k++) begin
         automatic bit fire = in_valid[k] && in_ready[k];
         fired[k] = fire;
         if (r) begin
            exp_q[k].delete();
            zero_flag[k] = 1'b1;
         end else if (f) begin
            exp_q[k].delete();
            if (k == 1) exp_q[k].push_back(NOP);
            zero_flag[k] = 1'b0;
         end else if (fire) begin
            exp_q[k].push_back(in_data[k]);
            zero_flag[k] = 1'b0;
         end
      end
   endtask

   task automatic set_next(input beat_t v);
      for (int k = 0; k < 2; k++) next_val[k] = v;
   endtask

   task automatic drain(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      mon_en    = 1'b0;
      rand_data = 1'b0;
      rst       = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid[k]  = 1'b0;
         in_data[k]   = '0;
         fired[k]     = 1'b0;
         zero_flag[k] = 1'b0;
`ifdef ELASTIC_PIPE_REG_PERF_EN
         stall_m[k] = 0;
         flush_m[k] = 0;
`endif
      end

      step(1'b1, 1'b0, 1'b0, 1'b0);
      mon_en = 1'b1;
      step(1'b1, 1'b0, 1'b0, 1'b0);

      // Back-to-back stream 1..8 with downstream always ready.
      set_next(beat_t'(1));
      repeat (8) step(1'b0, 1'b0, 1'b1, 1'b1);
      drain(3);

      // A, B absorbed while stalled, C waits upstream, then all drain in order.
      set_next(beat_t'('hA));
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
      drain(5);

      // Fill to FULL, flush, then hold the NOP for a cycle before draining.
      set_next(beat_t'('hA));
      repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      drain(3);

      // Flush in the same cycle D is handshaked.
      set_next(beat_t'('hD));
      step(1'b0, 1'b1, 1'b1, 1'b1);
      drain(3);

      // Reset and flush together while FULL: no NOP afterwards.
      set_next(beat_t'('h20));
      repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      drain(3);

      // Five stalled cycles with a valid beat on the output.
      set_next(beat_t'('h30));
      step(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0);
      drain(3);

      // Randomised traffic, stalls, flushes and occasional resets.
      rand_data = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         automatic bit r  = ($urandom_range(0, 149) == 0);
         automatic bit f  = ($urandom_range(0, 24) == 0);
         automatic bit rd = (i % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         automatic bit of = ($urandom_range(0, 2) != 0);
         step(r, f, rd, of);
      end
      drain(5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
